// File: rtl/flow_sel_gen.sv
// Heavy/light traffic flow request generator: per-frame detection counting, streak
// hysteresis, and hand-over at phase boundaries. Optional frame-loss timeout: FLOW_TIMEOUT_EN.
module flow_sel_gen #(
    parameter int CNT_W       = 8,
    parameter int HIGH_TH     = 12,
    parameter int LOW_TH      = 6,
    parameter int HOLD_FRAMES = 4,
    parameter int TIMEOUT_CYC = 100_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             car_det,
    input  logic             frame_end,
    input  logic             tr_valid,
    output logic             traffic_sel,
    output logic             sel_pending,
    output logic             sel_changed,
    output logic [CNT_W-1:0] frame_cnt
);

    // state       | meaning
    // ST_LIGHT     | light flow granted, no request
    // ST_LIGHT_PEND| light flow granted, heavy requested, waiting for tr_valid
    // ST_HEAVY     | heavy flow granted, no request
    // ST_HEAVY_PEND| heavy flow granted, light requested, waiting for tr_valid
    // Bit 1 is the granted flow and bit 0 the pending flag, so both outputs come straight off flops.
    typedef enum logic [1:0] {
        ST_LIGHT      = 2'b00,
        ST_LIGHT_PEND = 2'b01,
        ST_HEAVY      = 2'b10,
        ST_HEAVY_PEND = 2'b11
    } state_t;

    localparam int               STR_W   = 4;
    localparam logic [STR_W-1:0] HOLD_L  = STR_W'(HOLD_FRAMES);
    localparam logic [STR_W-1:0] HOLD_M1 = STR_W'(HOLD_FRAMES - 1);
    localparam logic [CNT_W-1:0] HIGH_L  = CNT_W'(HIGH_TH);
    localparam logic [CNT_W-1:0] LOW_L   = CNT_W'(LOW_TH);

    if (LOW_TH >= HIGH_TH || HOLD_FRAMES < 1 || HOLD_FRAMES > 15 || TIMEOUT_CYC < 1 ||
        HIGH_TH > (1 << CNT_W) - 1) begin : g_param_check
        $error("flow_sel_gen: inconsistent parameter set");
    end

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   acc_q, acc_d, acc_inc;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [STR_W-1:0]   heavy_q, heavy_d, light_q, light_d;
    logic               heavy_frame, light_frame;
    logic               heavy_hit, light_hit;
    logic               sel_changed_q, sel_changed_d;
    logic               timeout;

`ifdef FLOW_TIMEOUT_EN
    localparam int              TO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] to_q, to_d;

    // Down-counter reloaded by every frame_end; terminal count means the camera went quiet.
    always_comb begin
        timeout = !frame_end && (to_q == '0);
        to_d    = (frame_end || timeout) ? TO_LOAD : to_q - 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) to_q <= TO_LOAD;
        else        to_q <= to_d;
    end
`else
    assign timeout = 1'b0;
`endif

    // Closing count includes a detection landing in the frame_end cycle.
    always_comb begin
        acc_inc     = (car_det && acc_q != '1) ? acc_q + 1'b1 : acc_q;
        heavy_frame = (acc_inc >= HIGH_L);
        light_frame = (acc_inc <= LOW_L);
        frame_cnt_d = frame_cnt_q;
        acc_d       = acc_inc;
        if (frame_end) begin
            frame_cnt_d = acc_inc;
            acc_d       = '0;
        end else if (timeout) begin
            acc_d = '0;
        end
    end

    // Hits fire only on the frame that brings a streak up to HOLD_FRAMES.
    always_comb begin
        heavy_d   = heavy_q;
        light_d   = light_q;
        heavy_hit = 1'b0;
        light_hit = 1'b0;
        if (frame_end) begin
            if (heavy_frame) begin
                heavy_d   = (heavy_q == HOLD_L) ? heavy_q : heavy_q + 1'b1;
                light_d   = '0;
                heavy_hit = (heavy_q == HOLD_M1);
            end else if (light_frame) begin
                light_d   = (light_q == HOLD_L) ? light_q : light_q + 1'b1;
                heavy_d   = '0;
                light_hit = (light_q == HOLD_M1);
            end else begin
                heavy_d = '0;
                light_d = '0;
            end
        end else if (timeout) begin
            heavy_d = '0;
            light_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q       <= '0;
            frame_cnt_q <= '0;
            heavy_q     <= '0;
            light_q     <= '0;
        end else begin
            acc_q       <= acc_d;
            frame_cnt_q <= frame_cnt_d;
            heavy_q     <= heavy_d;
            light_q     <= light_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_LIGHT;
            sel_changed_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_changed_q <= sel_changed_d;
        end
    end

    // Fresh streak evidence cancels a pending request ahead of a coincident tr_valid.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LIGHT: begin
                if (heavy_hit) state_d = ST_LIGHT_PEND;
            end
            ST_LIGHT_PEND: begin
                if (timeout || light_hit) state_d = ST_LIGHT;
                else if (tr_valid)        state_d = ST_HEAVY;
            end
            ST_HEAVY: begin
                if (timeout || light_hit) state_d = ST_HEAVY_PEND;
            end
            ST_HEAVY_PEND: begin
                if (heavy_hit)     state_d = ST_HEAVY;
                else if (tr_valid) state_d = ST_LIGHT;
            end
            default: state_d = ST_LIGHT;
        endcase
        sel_changed_d = (state_d[1] != state_q[1]);
    end

    always_comb begin
        traffic_sel = state_q[1];
        sel_pending = state_q[0];
        sel_changed = sel_changed_q;
        frame_cnt   = frame_cnt_q;
    end

endmodule

// File: tb/tb_flow_sel_gen.sv
// Scoreboard bench for flow_sel_gen: directed plus randomized frames against a run-length model.
module tb_flow_sel_gen;

    localparam int HIGH   = 12;
    localparam int LOW    = 6;
    localparam int HOLD   = 4;
    localparam int MAXC   = 255;
    localparam int TO_CYC = 1000;

    logic       clk = 1'b0;
    logic       reset;
    logic       car_det, frame_end, tr_valid;
    logic       traffic_sel, sel_pending, sel_changed;
    logic [7:0] frame_cnt;

    always #5 clk = ~clk;

    flow_sel_gen #(
        .CNT_W(8), .HIGH_TH(HIGH), .LOW_TH(LOW), .HOLD_FRAMES(HOLD), .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk(clk), .reset(reset), .car_det(car_det), .frame_end(frame_end),
        .tr_valid(tr_valid), .traffic_sel(traffic_sel), .sel_pending(sel_pending),
        .sel_changed(sel_changed), .frame_cnt(frame_cnt)
    );

    typedef struct {
        bit    sel;
        bit    pend;
        bit    chg;
        int    fcnt;
        string tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: unbounded run lengths of heavy/light frames plus granted/pending flags.
    int m_acc, m_fcnt, m_hrun, m_lrun, m_idle;
    bit m_sel, m_pend, m_chg;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, expv);
    endtask

    task automatic m_reset();
        m_acc = 0; m_fcnt = 0; m_hrun = 0; m_lrun = 0; m_idle = 0;
        m_sel = 0; m_pend = 0; m_chg = 0;
    endtask

    task automatic model(input bit car, input bit fe, input bit tv, input string tag);
        int c;
        bit hreach, lreach, to, old_pend;
        exp_t e;
        hreach = 0; lreach = 0; to = 0;
        old_pend = m_pend;
        m_chg = 0;
        c = m_acc + int'(car);
        if (c > MAXC) c = MAXC;
        if (fe) begin
            m_fcnt = c;
            m_acc  = 0;
            if (c >= HIGH)     begin m_hrun++; m_lrun = 0; end
            else if (c <= LOW) begin m_lrun++; m_hrun = 0; end
            else               begin m_hrun = 0; m_lrun = 0; end
            hreach = (m_hrun == HOLD);
            lreach = (m_lrun == HOLD);
        end else begin
            m_acc = c;
        end
`ifdef FLOW_TIMEOUT_EN
        if (fe) m_idle = 0;
        else begin
            m_idle++;
            if (m_idle == TO_CYC) begin
                to = 1; m_idle = 0; m_acc = 0; m_hrun = 0; m_lrun = 0;
            end
        end
`endif
        if (to) begin
            if (m_sel && !m_pend)      m_pend = 1;
            else if (!m_sel && m_pend) m_pend = 0;
            else if (m_sel && m_pend && tv) begin m_sel = 0; m_pend = 0; m_chg = 1; end
        end else if (!m_pend) begin
            if ((!m_sel && hreach) || (m_sel && lreach)) m_pend = 1;
        end else begin
            if (m_sel ? hreach : lreach) m_pend = 0;
            else if (tv) begin m_sel = !m_sel; m_pend = 0; m_chg = 1; end
        end
        if (fe || tv || (m_pend != old_pend)) begin
            e.sel = m_sel; e.pend = m_pend; e.chg = m_chg; e.fcnt = m_fcnt; e.tag = tag;
            exp_q.push_back(e);
        end
    endtask

    task automatic step(input bit car, input bit fe, input bit tv, input string tag);
        car_det = car; frame_end = fe; tr_valid = tv;
        @(posedge clk);
        model(car, fe, tv, tag);
        #1;
        car_det = 0; frame_end = 0; tr_valid = 0;
    endtask

    task automatic frame(input int n, input bit car_at_end, input bit tv_at_end, input string tag);
        for (int i = 0; i < n; i++) step(1, 0, 0, tag);
        step(car_at_end, 1, tv_at_end, tag);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, "idle");
    endtask

    // Monitor: the DUT presents a response after frame_end/tr_valid, or whenever pending/changed move.
    logic prev_ev = 1'b0;
    bit   last_pend = 1'b0;
    exp_t mon_e;

    always @(posedge clk) prev_ev <= frame_end | tr_valid;

    always @(negedge clk) begin
        if (reset && (prev_ev || (sel_pending != last_pend) || sel_changed)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_response", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk({mon_e.tag, ".traffic_sel"}, int'(traffic_sel), int'(mon_e.sel));
                chk({mon_e.tag, ".sel_pending"}, int'(sel_pending), int'(mon_e.pend));
                chk({mon_e.tag, ".sel_changed"}, int'(sel_changed), int'(mon_e.chg));
                chk({mon_e.tag, ".frame_cnt"},   int'(frame_cnt),   mon_e.fcnt);
            end
        end
        last_pend = sel_pending;
    end

    task automatic do_reset();
        reset = 1'b0;
        #2;
        chk("reset.traffic_sel", int'(traffic_sel), 0);
        chk("reset.sel_pending", int'(sel_pending), 0);
        chk("reset.sel_changed", int'(sel_changed), 0);
        chk("reset.frame_cnt",   int'(frame_cnt),   0);
        m_reset();
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        car_det = 0; frame_end = 0; tr_valid = 0;
        m_reset();
        @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < 4; i++) frame(15, 0, 0, "heavy15");
        idle(2);
        step(0, 0, 1, "grant_heavy");
        idle(2);

        frame(3, 0, 0, "f3"); frame(4, 0, 0, "f4"); frame(9, 0, 0, "f9_break");
        frame(2, 0, 0, "f2"); frame(1, 0, 0, "f1"); frame(0, 0, 0, "f0"); frame(5, 0, 0, "f5_pend");
        idle(1);
        step(0, 0, 1, "grant_light");
        idle(2);

        frame(11, 1, 0, "sat_same_cycle");
        frame(300, 0, 0, "sat_300");

        frame(15, 0, 0, "lp_a"); frame(15, 0, 0, "lp_b");
        for (int i = 0; i < 4; i++) frame(2, 0, 0, "lp_cancel");
        idle(1);
        step(0, 0, 1, "tv_after_cancel");
        idle(2);

        for (int i = 0; i < 4; i++) frame(20, 0, 0, "pre_reset");
        for (int i = 0; i < 5; i++) step(1, 0, 0, "partial");
        do_reset();
        frame(0, 0, 0, "post_reset_empty");

        for (int i = 0; i < 3; i++) frame(15, 0, 0, "coinc");
        frame(15, 0, 1, "coinc_fe_tv");
        idle(1);
        step(0, 0, 1, "coinc_grant");
        idle(2);

        for (int f = 0; f < 250; f++) begin
            int n;
            n = ($urandom_range(0, 19) == 0) ? 260 : $urandom_range(0, 16);
            for (int i = 0; i < n; i++) begin
                step(1, 0, ($urandom_range(0, 15) == 0), "rnd");
                if ($urandom_range(0, 1) == 1) step(0, 0, ($urandom_range(0, 15) == 0), "rnd");
            end
            step(1'($urandom_range(0, 1)), 1, ($urandom_range(0, 5) == 0), "rnd_fe");
        end
        idle(3);

`ifdef FLOW_TIMEOUT_EN
        do_reset();
        for (int i = 0; i < 4; i++) frame(15, 0, 0, "to_heavy");
        step(0, 0, 1, "to_grant");
        idle(TO_CYC + 10);
        step(0, 0, 1, "to_failsafe");
        idle(3);
`endif

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/flow_sel_gen.md
# flow_sel_gen

Generates the `traffic_sel` flow-state request for the traffic signal control unit from the VGA vision pipeline's vehicle-detection strobes. Counts detections per video frame and applies threshold hysteresis across consecutive frames. Hands the resulting heavy/light decision to the signal controller only at the controller's phase-boundary pulse, so a light phase is never cut mid-count. Sits between the image-processing detector and the signal control unit.

## Interface
- `CNT_W`, 8: width of the per-frame detection counter.
- `HIGH_TH`, 12: detections per frame at or above which a frame is "heavy".
- `LOW_TH`, 6: detections per frame at or below which a frame is "light". Must be less than `HIGH_TH`.
- `HOLD_FRAMES`, 4: consecutive heavy or light frames required to raise a request (1..15).
- `TIMEOUT_CYC`, 100_000_000: frame-absence timeout in clocks; used only with `FLOW_TIMEOUT_EN`.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `car_det` in 1: one-cycle pulse per vehicle detected in the current frame.
- `frame_end` in 1: one-cycle pulse at end of each video frame (vsync edge).
- `tr_valid` in 1: one-cycle pulse from the signal control unit at each phase boundary; the only point where `traffic_sel` may change.
- `traffic_sel` out 1: 0 = light flow, 1 = heavy flow. Registered.
- `sel_pending` out 1: high while the internal request differs from `traffic_sel`.
- `sel_changed` out 1: one-cycle pulse in the cycle after `traffic_sel` toggles.
- `frame_cnt` out CNT_W: detection count of the last closed frame.

## Operation
- Detection counter `acc` increments on `car_det` and saturates at 2^CNT_W−1.
- On `frame_end`:
  - `frame_cnt` ← `acc`, including a `car_det` in the same cycle (saturating).
  - `acc` ← 0.
- Streak counters are updated at `frame_end` using the closing count `c`; both saturate at `HOLD_FRAMES`.
  - `c >= HIGH_TH`: heavy_streak+1, light_streak←0.
  - `c <= LOW_TH`: light_streak+1, heavy_streak←0.
  - Otherwise both ← 0.
- FSM states (reset: LIGHT):
  - LIGHT: heavy_streak reaching `HOLD_FRAMES` → LIGHT_PEND.
  - LIGHT_PEND: `tr_valid` → HEAVY (traffic_sel←1). light_streak reaching `HOLD_FRAMES` → LIGHT (request cancelled).
  - HEAVY: light_streak reaching `HOLD_FRAMES` → HEAVY_PEND.
  - HEAVY_PEND: `tr_valid` → LIGHT (traffic_sel←0). heavy_streak reaching `HOLD_FRAMES` → HEAVY (request cancelled).
- `sel_pending` = state is LIGHT_PEND or HEAVY_PEND.
- `tr_valid` in LIGHT or HEAVY is ignored.
- Reaching `HOLD_FRAMES` is the transition edge, not the saturated level. Once saturated, the streak stays saturated until broken.

## Timing
- Reset values: `traffic_sel`=0, `sel_pending`=0, `sel_changed`=0, `frame_cnt`=0, `acc`=0, streaks=0, state LIGHT.
- `frame_end` at cycle t: `frame_cnt` and streaks valid at t+1. A pending request from that frame shows on `sel_pending` at t+1.
- `tr_valid` at cycle t with `sel_pending`=1 at t: `traffic_sel` toggles at t+1, `sel_pending` falls at t+1, `sel_changed`=1 for cycle t+1 only.
- `tr_valid` in the same cycle as the `frame_end` that creates a request: not honoured. The request waits for the next `tr_valid`.
- Reset asserted mid-frame or mid-pending: all state cleared immediately. The partial frame count is discarded.

## Configuration
- `FLOW_TIMEOUT_EN` defined:
  - A counter clears on every `frame_end`.
  - On reaching `TIMEOUT_CYC` clocks with no `frame_end`: streaks clear, `acc` clears, and the FSM is forced to HEAVY_PEND if in HEAVY (LIGHT_PEND → LIGHT). Camera loss thus fails safe to light flow at the next `tr_valid`.
  - The counter then restarts.
- Undefined: no timeout logic. The last decision holds indefinitely.

## Test plan
- Reset, then 3 frames of 15 detections → `frame_cnt`=15, `sel_pending`=0, `traffic_sel`=0. Fourth frame of 15 → `sel_pending`=1 one cycle after `frame_end`.
- Pending heavy, pulse `tr_valid` → `traffic_sel`=1 and `sel_changed`=1 next cycle; `sel_pending`=0.
- In HEAVY: frames 3, 4, 9, 2, 1, 0, 5 → the 9 breaks the streak. Pending asserts only after frame 5 (fourth consecutive ≤6). `tr_valid` then returns `traffic_sel` to 0.
- `car_det` and `frame_end` in the same cycle with 11 prior detections → `frame_cnt`=12. 300 detections in one frame → `frame_cnt`=255.
- In LIGHT_PEND, four frames of 2 before any `tr_valid` → `sel_pending` drops; a later `tr_valid` leaves `traffic_sel`=0.
- With `FLOW_TIMEOUT_EN` and `TIMEOUT_CYC`=1000, in HEAVY, no `frame_end` for 1000 cycles → `sel_pending`=1. The next `tr_valid` gives `traffic_sel`=0.
